// File: rtl/fetch_queue.sv
// fetch_queue: PC owner and DEPTH-entry instruction/next-PC queue feeding IF/ID.
// Optional combinational empty-queue bypass enabled by defining FETCHQ_BYPASS_EN.
module fetch_queue #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = 4,
  parameter int RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable_pc,
  input  logic                       branch,
  input  logic [ADDR_W-1:0]          branch_target,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [DATA_W-1:0]          imem_data,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [DATA_W-1:0]          id_instr,
  output logic [ADDR_W-1:0]          id_next_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0] npc_q [DEPTH];
  logic              fetch_ok, bypass, pop, pop_mem, fetch, write;

  assign pc_inc    = pc_q + ADDR_W'(PC_STEP);
  assign imem_addr = pc_q;
  assign count     = count_q;
  assign empty     = count_q == '0;
  assign full      = count_q == CW'(DEPTH);

  always_comb begin
    fetch_ok = enable_pc & ~branch;
`ifdef FETCHQ_BYPASS_EN
    bypass = reset & empty & fetch_ok;
`else
    bypass = 1'b0;
`endif
    id_valid   = ~empty | bypass;
    id_instr   = bypass ? imem_data : empty ? '0 : instr_q[rd_ptr_q];
    id_next_pc = bypass ? pc_inc : empty ? '0 : npc_q[rd_ptr_q];
    pop        = id_valid & id_ready & ~branch;
    pop_mem    = pop & ~empty;
    fetch      = fetch_ok & (~full | pop);
    // a bypassed word consumed in the same cycle never touches storage
    write      = fetch & ~(bypass & pop);
    pc_d       = branch ? branch_target : fetch ? pc_inc : pc_q;
    wr_ptr_d   = branch ? '0 : write ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = branch ? '0 : pop_mem ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = branch ? '0 : count_q + CW'(write) - CW'(pop_mem);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= ADDR_W'(RESET_PC);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (write) begin
      instr_q[wr_ptr_q] <= imem_data;
      npc_q[wr_ptr_q]   <= pc_inc;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scenario tasks plus randomized run against a queue-based fetch model.
module tb_fetch_queue;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable_pc, branch, id_ready, id_valid, full, empty;
  logic [7:0]  branch_target, imem_addr, id_next_pc;
  logic [31:0] imem_data, id_instr;
  logic [2:0]  count;
  logic        w_en, w_br, w_rdy, w_valid, w_full, w_empty;
  logic [7:0]  w_tgt, w_addr, w_npc;
  logic [31:0] w_data, w_instr;
  logic [2:0]  w_count;
  logic [31:0] rom [64];
  logic [39:0] mq [$];
  logic [7:0]  m_pc;
  int n_chk = 0, n_fail = 0;

  assign imem_data = rom[imem_addr[7:2]];
  assign w_data    = rom[w_addr[7:2]];

  fetch_queue dut (
    .clk(clk), .reset(reset), .enable_pc(enable_pc), .branch(branch),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
    .id_next_pc(id_next_pc), .count(count), .full(full), .empty(empty)
  );

  fetch_queue #(.RESET_PC(8'hFC)) u_wrap (
    .clk(clk), .reset(reset), .enable_pc(w_en), .branch(w_br),
    .branch_target(w_tgt), .imem_addr(w_addr), .imem_data(w_data),
    .id_ready(w_rdy), .id_valid(w_valid), .id_instr(w_instr),
    .id_next_pc(w_npc), .count(w_count), .full(w_full), .empty(w_empty)
  );

  task automatic cyc(input logic e, input logic b, input logic [7:0] t, input logic r);
    bit p, f;
    enable_pc = e; branch = b; branch_target = t; id_ready = r;
    p = mq.size() > 0 && r && !b;
    f = e && !b && (mq.size() < 4 || p);
    @(posedge clk);
    if (b) begin
      mq.delete();
      m_pc = t;
    end else begin
      if (p) void'(mq.pop_front());
      if (f) begin
        mq.push_back({rom[m_pc[7:2]], m_pc + 8'd4});
        m_pc = m_pc + 8'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_chk++; if ({empty, full, id_valid} !== 3'b100) begin n_fail++; $display("FAIL reset_flags got %b want 100", {empty, full, id_valid}); end
    n_chk++; if (id_instr !== 32'd0 || id_next_pc !== 8'd0) begin n_fail++; $display("FAIL reset_head got %h/%h want 0/0", id_instr, id_next_pc); end
    n_chk++; if (imem_addr !== 8'd0) begin n_fail++; $display("FAIL reset_pc got %h want 00", imem_addr); end
  endtask

  task automatic test_sequence;
    logic [31:0] exp [3];
    exp[0] = 32'hE3A01001; exp[1] = 32'hE3A02002; exp[2] = 32'hE0813002;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1);
      n_chk++; if (id_valid !== 1'b1 || id_instr !== exp[i]) begin n_fail++; $display("FAIL seq_instr%0d got %b/%h want 1/%h", i, id_valid, id_instr, exp[i]); end
      n_chk++; if (id_next_pc !== 8'(4 * (i + 1))) begin n_fail++; $display("FAIL seq_npc%0d got %h want %h", i, id_next_pc, 4 * (i + 1)); end
      n_chk++; if (count > 3'd1) begin n_fail++; $display("FAIL seq_count%0d got %0d want <=1", i, count); end
    end
  endtask

  task automatic test_stall_drain;
    cyc(1, 1, 8'h00, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0, 0);
      n_chk++; if (count !== 3'((i < 4) ? i + 1 : 4)) begin n_fail++; $display("FAIL stall_count%0d got %0d want %0d", i, count, (i < 4) ? i + 1 : 4); end
    end
    n_chk++; if (full !== 1'b1 || imem_addr !== 8'd16) begin n_fail++; $display("FAIL stall_full got %b/%h want 1/10", full, imem_addr); end
    for (int k = 0; k < 6; k++) begin
      n_chk++; if (id_instr !== rom[k] || id_next_pc !== 8'(4 * k + 4)) begin n_fail++; $display("FAIL drain_head%0d got %h/%h want %h/%h", k, id_instr, id_next_pc, rom[k], 4 * k + 4); end
      cyc(1, 0, 0, 1);
      n_chk++; if (count !== 3'd4) begin n_fail++; $display("FAIL drain_count%0d got %0d want 4", k, count); end
    end
    n_chk++; if (imem_addr !== 8'd40) begin n_fail++; $display("FAIL drain_pc got %h want 28", imem_addr); end
  endtask

  task automatic test_branch;
    cyc(1, 1, 8'h00, 0);
    repeat (3) cyc(1, 0, 0, 0);
    n_chk++; if (count !== 3'd3) begin n_fail++; $display("FAIL br_pre_count got %0d want 3", count); end
    cyc(1, 1, 8'h40, 1);
    n_chk++; if (count !== 3'd0 || id_valid !== 1'b0 || id_instr !== 32'd0) begin n_fail++; $display("FAIL br_flush got %0d/%b/%h want 0/0/0", count, id_valid, id_instr); end
    n_chk++; if (imem_addr !== 8'h40) begin n_fail++; $display("FAIL br_pc got %h want 40", imem_addr); end
    cyc(1, 0, 0, 1);
    n_chk++; if (id_valid !== 1'b1 || id_next_pc !== 8'h44 || id_instr !== rom[16]) begin n_fail++; $display("FAIL br_target got %b/%h/%h want 1/44/%h", id_valid, id_next_pc, id_instr, rom[16]); end
  endtask

  task automatic test_wrap;
    n_chk++; if (w_addr !== 8'hFC) begin n_fail++; $display("FAIL wrap_reset_pc got %h want fc", w_addr); end
    w_en = 1'b1;
    @(posedge clk); @(negedge clk);
    w_en = 1'b0;
    n_chk++; if (w_addr !== 8'h00) begin n_fail++; $display("FAIL wrap_pc got %h want 00", w_addr); end
    n_chk++; if (w_valid !== 1'b1 || w_npc !== 8'h00 || w_instr !== rom[63]) begin n_fail++; $display("FAIL wrap_head got %b/%h/%h want 1/00/%h", w_valid, w_npc, w_instr, rom[63]); end
  endtask

  task automatic test_async_reset;
    cyc(1, 1, 8'h20, 0);
    repeat (2) cyc(1, 0, 0, 0);
    n_chk++; if (count !== 3'd2 || id_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre got %0d/%b want 2/1", count, id_valid); end
    #2 reset = 1'b0;
    #1;
    n_chk++; if (id_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL ar_state got %b/%0d/%b want 0/0/1", id_valid, count, empty); end
    n_chk++; if (imem_addr !== 8'h00 || id_instr !== 32'd0) begin n_fail++; $display("FAIL ar_pc got %h/%h want 00/0", imem_addr, id_instr); end
    @(negedge clk);
    enable_pc = 1'b0;
    reset = 1'b1;
    mq.delete();
    m_pc = 8'h00;
  endtask

  task automatic test_random;
    logic [53:0] got, want;
    logic [39:0] h;
    for (int it = 0; it < 400; it++) begin
      h = (mq.size() > 0) ? mq[0] : 40'd0;
      want = {mq.size() > 0, h, 3'(mq.size()), mq.size() == 4, mq.size() == 0, m_pc};
      got  = {id_valid, id_instr, id_next_pc, count, full, empty, imem_addr};
      n_chk++; if (got !== want) begin n_fail++; $display("FAIL rand%0d got %h want %h", it, got, want); end
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, 8'($urandom),
          $urandom_range(0, 99) < ((it < 200) ? 40 : 85));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'hE3A01001; rom[1] = 32'hE3A02002; rom[2] = 32'hE0813002;
    enable_pc = 0; branch = 0; branch_target = 0; id_ready = 0;
    w_en = 0; w_br = 0; w_tgt = 0; w_rdy = 0;
    m_pc = 8'h00;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    reset = 1'b1;
    test_sequence;
    test_stall_drain;
    test_branch;
    test_wrap;
    test_async_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
